bsg_fifo_shared_enq_arb: RTL and testbench
==========================================

// Module: bsg_fifo_shared_enq_arb
// PURPOSE
//  Shares one FIFO storage array (els_p slots) among num_req_p enqueue requesters.
//  Round-robin arbiter picks one requester per cycle; pointer/occupancy tracker drives array wptr/rptr.
//  Single consumer dequeues. Sits between requesters and a 1R1W RAM holding the payload.
// PARAMETERS
//  els_p      256  FIFO depth; power of two, >= 2
//  num_req_p  4    number of enqueue requesters, >= 1
//  lg_els_lp  $clog2(els_p)      pointer width (localparam)
//  cnt_w_lp   $clog2(els_p+1)    occupancy width (localparam)
//  id_w_lp    max(1,$clog2(num_req_p))  grant id width (localparam)
// PORTS
//  clk_i      in   1          clock
//  reset_i    in   1          synchronous, active-high reset
//  v_i        in   num_req_p  per-requester enqueue valid
//  yumi_o     out  num_req_p  one-hot accept; requester data written this cycle
//  wen_o      out  1          RAM write enable (= |yumi_o)
//  wid_o      out  id_w_lp    index of granted requester (RAM data mux select)
//  wptr_o     out  lg_els_lp  RAM write address (registered write pointer)
//  deq_i      in   1          consumer dequeue; legal only when v_o=1
//  v_o        out  1          FIFO non-empty
//  rptr_o     out  lg_els_lp  RAM read address (registered read pointer)
//  rptr_n_o   out  lg_els_lp  next read pointer (for sync-read RAM prefetch)
//  count_o    out  cnt_w_lp   occupancy, 0..els_p
//  full_o     out  1          count_o == els_p
//  empty_o    out  1          count_o == 0
// BEHAVIOUR
//  Reset: wptr/rptr=0, count_o=0, empty_o=1, full_o=0, v_o=0, last_grant=num_req_p-1 (req 0 first).
//  Grant (comb., same cycle): if ~full_o, pick first i with v_i[i] searching last_grant+1 .. wrapping.
//   yumi_o one-hot or zero; v_i->yumi_o combinational; yumi_o never depends on deq_i.
//  Full blocks all grants even if deq_i same cycle (no full bypass); yumi_o=0 whenever full_o.
//  last_grant updates only on a grant; unchanged when no v_i or full.
//  Enq: wptr += 1 mod els_p on wen_o; data write addr = current wptr_o (zero write latency).
//  Deq: rptr += 1 mod els_p when deq_i & v_o; rptr_n_o = deq_i&v_o ? rptr+1 : rptr.
//   deq_i while empty: ignored, no state change (assertion fires in sim).
//  Simultaneous enq+deq (non-empty, non-full): count_o unchanged, both pointers advance.
//  Enq into empty: v_o rises next cycle (1-cycle enq->deq latency; no bypass).
//  count_o: +1 enq only, -1 deq only; full_o/empty_o derived from count_o, registered.
//  Wrap: pointers roll els_p-1 -> 0; full when wptr==rptr and count==els_p.
//  Reset mid-operation: all contents discarded; returns to reset state next cycle.
// CONFIGURATION
//  BSG_FIFO_SHARED_ARB_HWM_EN defined: adds output hwm_o [cnt_w_lp] = max count_o
//   since reset; updates the cycle after count_o exceeds it; reset 0.
//  Not defined: hwm_o port and its register absent; all other behaviour identical.
// STRUCTURE
//  Package bsg_fifo_shared_arb_pkg: ptr/count/id width functions, grant struct
//   {v, id, onehot}.
//  Sub-module bsg_rr_pick_onehot: round-robin picker (reqs, last_grant) -> onehot/id;
//   pure comb., instantiated once; tracker/counters stay in top.
// TESTING
//  T1 reset, v_i=4'b1111 held, no deq -> grants 0,1,2,3,0... one per cycle; wptr_o 0,1,2,...
//  T2 els_p=4: fill 4 -> full_o=1, count_o=4, yumi_o=0; deq+v_i same cycle -> no grant,
//     count_o=3 next cycle.
//  T3 empty, deq_i=1 -> no pointer change, v_o=0; enq at t -> v_o=1 at t+1.
//  T4 els_p=4: 10 enq/deq pairs steady -> count_o const 1, rptr_o/wptr_o wrap 3->0 cleanly.
//  T5 v_i=4'b0101, last grant 0 -> grant 2 then 0; v_i=0 -> last_grant held.
//  T6 reset asserted with count_o=3 -> next cycle count_o=0, empty_o=1, pointers 0;
//     with HWM_EN hwm_o=0.

Source files
------------

// File: rtl/bsg_fifo_shared_arb_pkg.sv
// Shared-enqueue FIFO arbiter: width helpers and the grant record.
// Optional feature macro used by the top: BSG_FIFO_SHARED_ARB_HWM_EN.
package bsg_fifo_shared_arb_pkg;

  // Upper bounds for the grant record; num_req_p must not exceed max_req_lp.
  localparam int max_req_lp  = 64;
  localparam int max_id_w_lp = 6;

  function automatic int ptr_w(input int els);
    return $clog2(els);
  endfunction

  function automatic int cnt_w(input int els);
    return $clog2(els + 1);
  endfunction

  function automatic int id_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  typedef struct packed {
    logic                   v;
    logic [max_id_w_lp-1:0] id;
    logic [max_req_lp-1:0]  onehot;
  } grant_s;

endpackage

// File: rtl/bsg_fifo_shared_enq_arb_pick.sv
// Round-robin picker: first requester after last_grant, wrapping. Pure combinational.
module bsg_rr_pick_onehot
  import bsg_fifo_shared_arb_pkg::*;
#(
  parameter int num_req_p = 4,
  parameter int id_w_lp   = 2
) (
  input  logic [num_req_p-1:0] reqs,
  input  logic [id_w_lp-1:0]   last_grant,
  output grant_s               grant
);

  logic [id_w_lp-1:0] idx;

  // Scan last_grant+1 .. last_grant+num_req_p (mod num_req_p); keep the first hit.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int k = 1; k <= num_req_p; k++) begin
      idx = id_w_lp'((int'(last_grant) + k) % num_req_p);
      if (!grant.v && reqs[idx]) begin
        grant.v                            = 1'b1;
        grant.id                           = max_id_w_lp'(idx);
        grant.onehot[max_id_w_lp'(idx)]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bsg_fifo_shared_enq_arb.sv
// Shared FIFO pointer/occupancy tracker with round-robin enqueue arbitration.
// Payload lives in an external 1R1W RAM addressed by wptr_o/rptr_o.
// Define BSG_FIFO_SHARED_ARB_HWM_EN to add the hwm_o occupancy high-water mark.
module bsg_fifo_shared_enq_arb
  import bsg_fifo_shared_arb_pkg::*;
#(
  parameter  int els_p     = 256,
  parameter  int num_req_p = 4,
  localparam int lg_els_lp = ptr_w(els_p),
  localparam int cnt_w_lp  = cnt_w(els_p),
  localparam int id_w_lp   = id_w(num_req_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [num_req_p-1:0] v_i,
  output logic [num_req_p-1:0] yumi_o,
  output logic                 wen_o,
  output logic [id_w_lp-1:0]   wid_o,
  output logic [lg_els_lp-1:0] wptr_o,
  input  logic                 deq_i,
  output logic                 v_o,
  output logic [lg_els_lp-1:0] rptr_o,
  output logic [lg_els_lp-1:0] rptr_n_o,
  output logic [cnt_w_lp-1:0]  count_o,
  output logic                 full_o,
  output logic                 empty_o
`ifdef BSG_FIFO_SHARED_ARB_HWM_EN
  ,output logic [cnt_w_lp-1:0] hwm_o
`endif
);

  localparam logic [cnt_w_lp-1:0] cnt_full_lp = cnt_w_lp'(els_p);

  logic [id_w_lp-1:0]   last_grant;
  logic [num_req_p-1:0] reqs;
  grant_s               grant;
  logic                 deq_fire;
  logic [cnt_w_lp-1:0]  count_n;
  logic                 unused_grant_bits;

  // No full bypass: a dequeue in the same cycle does not free a slot for enqueue.
  assign reqs = full_o ? '0 : v_i;

  bsg_rr_pick_onehot #(
    .num_req_p (num_req_p),
    .id_w_lp   (id_w_lp)
  ) pick (
    .reqs       (reqs),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign yumi_o            = grant.onehot[num_req_p-1:0];
  assign wen_o             = grant.v;
  assign wid_o             = grant.id[id_w_lp-1:0];
  assign unused_grant_bits = ^grant;

  assign deq_fire = deq_i & v_o;
  assign v_o      = ~empty_o;
  assign rptr_n_o = deq_fire ? rptr_o + lg_els_lp'(1) : rptr_o;

  // Occupancy next-state: simultaneous enq+deq leaves count unchanged.
  always_comb begin
    count_n = count_o;
    case ({wen_o, deq_fire})
      2'b10:   count_n = count_o + cnt_w_lp'(1);
      2'b01:   count_n = count_o - cnt_w_lp'(1);
      default: count_n = count_o;
    endcase
  end

  // Pointer, occupancy and arbitration-history registers; flags registered from count_n.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_o     <= '0;
      rptr_o     <= '0;
      count_o    <= '0;
      full_o     <= 1'b0;
      empty_o    <= 1'b1;
      last_grant <= id_w_lp'(num_req_p - 1);
    end else begin
      if (wen_o) begin
        wptr_o     <= wptr_o + lg_els_lp'(1);
        last_grant <= wid_o;
      end
      if (deq_fire) begin
        rptr_o <= rptr_o + lg_els_lp'(1);
      end
      count_o <= count_n;
      full_o  <= (count_n == cnt_full_lp);
      empty_o <= (count_n == '0);
    end
  end

`ifdef BSG_FIFO_SHARED_ARB_HWM_EN
  // High-water mark trails count_o by one cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hwm_o <= '0;
    end else if (count_o > hwm_o) begin
      hwm_o <= count_o;
    end
  end
`endif

  // A dequeue against an empty FIFO is dropped; flag it in simulation.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(deq_i && !v_o)) else $warning("deq_i asserted while empty; ignored");
    end
  end

endmodule

// File: tb/tb_bsg_fifo_shared_enq_arb.sv
// Bench for bsg_fifo_shared_enq_arb (els_p=4, num_req_p=4) against a counter/pointer model.
// Honors BSG_FIFO_SHARED_ARB_HWM_EN when defined.
module tb_bsg_fifo_shared_enq_arb;

  localparam int ELS  = 4;
  localparam int NREQ = 4;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [3:0] v_i;
  logic [3:0] yumi_o;
  logic       wen_o;
  logic [1:0] wid_o;
  logic [1:0] wptr_o;
  logic       deq_i;
  logic       v_o;
  logic [1:0] rptr_o;
  logic [1:0] rptr_n_o;
  logic [2:0] count_o;
  logic       full_o;
  logic       empty_o;
`ifdef BSG_FIFO_SHARED_ARB_HWM_EN
  logic [2:0] hwm_o;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Model state: occupancy, enqueue/dequeue positions, last granted requester, peak occupancy.
  int m_count, m_wptr, m_rptr, m_last, m_hwm;

  always #5 clk_i = ~clk_i;

  bsg_fifo_shared_enq_arb #(.els_p(ELS), .num_req_p(NREQ)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .v_i      (v_i),
    .yumi_o   (yumi_o),
    .wen_o    (wen_o),
    .wid_o    (wid_o),
    .wptr_o   (wptr_o),
    .deq_i    (deq_i),
    .v_o      (v_o),
    .rptr_o   (rptr_o),
    .rptr_n_o (rptr_n_o),
    .count_o  (count_o),
    .full_o   (full_o),
    .empty_o  (empty_o)
`ifdef BSG_FIFO_SHARED_ARB_HWM_EN
    ,.hwm_o   (hwm_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_wptr = 0; m_rptr = 0; m_last = NREQ - 1; m_hwm = 0;
  endtask

  // One clock: drive at negedge, check against the model before the edge, then advance the model.
  task automatic cycle(input logic rst, input logic [3:0] v, input logic deq);
    int g;
    bit deq_fire;
    @(negedge clk_i);
    reset_i = rst; v_i = v; deq_i = deq;
    #1;
    g = -1;
    if (m_count < ELS)
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && v[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
    deq_fire = deq && (m_count > 0);
    chk("yumi",   32'(yumi_o),   (g < 0) ? 32'd0 : 32'(1 << g));
    chk("wen",    32'(wen_o),    32'(g >= 0));
    if (g >= 0) chk("wid", 32'(wid_o), 32'(g));
    chk("wptr",   32'(wptr_o),   32'(m_wptr));
    chk("rptr",   32'(rptr_o),   32'(m_rptr));
    chk("rptr_n", 32'(rptr_n_o), 32'((m_rptr + int'(deq_fire)) % ELS));
    chk("count",  32'(count_o),  32'(m_count));
    chk("v_o",    32'(v_o),      32'(m_count > 0));
    chk("full",   32'(full_o),   32'(m_count == ELS));
    chk("empty",  32'(empty_o),  32'(m_count == 0));
`ifdef BSG_FIFO_SHARED_ARB_HWM_EN
    chk("hwm",    32'(hwm_o),    32'(m_hwm));
`endif
    @(posedge clk_i);
    if (rst) begin
      model_reset();
    end else begin
      if (m_count > m_hwm) m_hwm = m_count;
      if (g >= 0) begin
        m_wptr = (m_wptr + 1) % ELS;
        m_last = g;
        m_count++;
      end
      if (deq_fire) begin
        m_rptr = (m_rptr + 1) % ELS;
        m_count--;
      end
    end
  endtask

  initial begin
    reset_i = 1'b1; v_i = '0; deq_i = 1'b0;
    repeat (2) @(posedge clk_i);
    model_reset();

    // Reset state, then all requesters: grants 0,1,2,3 until full.
    cycle(1'b1, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 4'hF, 1'b0);
    // Full: dequeue with requests pending -> no grant, count drops to 3.
    cycle(1'b0, 4'hF, 1'b1);
    cycle(1'b0, 4'h0, 1'b0);
    // Round-robin wraps back to requester 0.
    cycle(1'b0, 4'hF, 1'b0);
    cycle(1'b0, 4'h0, 1'b1);
    // Reset mid-operation with count 3.
    cycle(1'b1, 4'hF, 1'b1);
    cycle(1'b0, 4'h0, 1'b0);
    // Dequeue while empty is ignored; enqueue shows v_o next cycle.
    cycle(1'b0, 4'h0, 1'b1);
    cycle(1'b0, 4'h1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    // Sparse requesters 0101 after grant 0 -> 2 then 0; idle holds last grant.
    cycle(1'b0, 4'h5, 1'b0);
    cycle(1'b0, 4'h5, 1'b0);
    cycle(1'b0, 4'h0, 1'b0);
    cycle(1'b0, 4'h5, 1'b1);
    // Steady enq/deq pairs at occupancy 1 across pointer wrap.
    cycle(1'b1, 4'h0, 1'b0);
    cycle(1'b0, 4'h8, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'hF, 1'b1);
    cycle(1'b0, 4'h0, 1'b0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic [3:0] v;
      logic       d;
      r = ($urandom_range(0, 59) == 0);
      v = 4'($urandom) & 4'($urandom);
      d = ($urandom_range(0, 2) != 0) && (m_count > 0);
      cycle(r, v, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
